det_round_ctrl: RTL and testbench
=================================

Name: det_round_ctrl

Overview:
- Round sequencer for the three-input first-signal detector (inputs a/b/c, sticky 3-bit one-hot-or-tie output y).
- Arms the detector by pulsing its active-low reset, waits for a non-zero y or a timeout, and reports the winner to a host with start/done signalling.
- Keeps saturating per-channel win scores and a round count.
- Sits between the host/test sequencer and one detector instance; owns the detector's reset input.

Parameters:
- ARM_CYCLES, 2, cycles det_rst_n is held low per round (>=1)
- TIMEOUT_CYCLES, 1000, WAIT-state cycles before declaring a no-winner round (>=1)
- CNT_W, 8, width of score and round counters

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous active-low reset
- start  in  1  single-cycle request to run one round; ignored unless IDLE
- abort  in  1  cancel an in-progress round
- clr_scores  in  1  synchronous clear of score_a/b/c and round_cnt
- det_y  in  3  detector output y (bit0=a, bit1=b, bit2=c)
- det_rst_n  out  1  drives detector rst; low = detector cleared/unlocked
- busy  out  1  high in ARM, WAIT, REPORT
- done  out  1  one-cycle pulse when a round completes (winner or timeout)
- timeout  out  1  held; 1 if last completed round timed out
- winner  out  3  held; det_y captured at round end, 000 on timeout
- tie  out  1  held; 1 if winner has more than one bit set
- score_a, score_b, score_c  out  CNT_W each  saturating win counts
- round_cnt  out  CNT_W  saturating count of completed rounds (incl. timeouts)

Behaviour:
- Reset (rst=0, async): state=IDLE, det_rst_n=0, busy=0, done=0, timeout=0, winner=000, tie=0, all counters 0. After rst release det_rst_n goes to 1 on the first clock edge.
- FSM states: IDLE, ARM, WAIT, REPORT.
- IDLE: det_rst_n=1, so the detector keeps its locked result. start=1 -> ARM next cycle. abort is ignored.
- ARM: det_rst_n=0 for exactly ARM_CYCLES cycles, counted by an internal arm counter. Then -> WAIT.
- WAIT: det_rst_n=1. A timeout counter starts at 0 and increments each WAIT cycle.
  - det_y!=000 sampled -> REPORT with capture of det_y.
  - Counter reaches TIMEOUT_CYCLES-1 with det_y==000 -> REPORT with winner=000, timeout=1.
  - If det_y!=000 in the final timeout cycle, detection wins (timeout=0).
- REPORT: lasts one cycle. done=1. winner/tie/timeout registers update on entry.
  - Each set bit of winner increments its score; a tie increments all involved channels.
  - round_cnt increments.
  - -> IDLE.
- Latency: start at edge N -> det_rst_n low for edges N+1..N+ARM_CYCLES.
  - If det_y is already non-zero on the first WAIT cycle, done is asserted in cycle N+ARM_CYCLES+2.
- abort in ARM or WAIT: -> IDLE next cycle, det_rst_n=1, no done, no score/round update, winner/timeout unchanged. abort in REPORT is ignored (the round completes).
- start while busy is dropped; it is not queued.
- Counters saturate at 2^CNT_W-1 and do not wrap.
- clr_scores zeroes all counters next cycle. If it coincides with REPORT, the clear wins and the increment is lost.
- winner, tie and timeout hold their values until the next REPORT. Only reset clears them; clr_scores does not.

Decomposition:
- Package det_ctrl_pkg:
  - state enum (IDLE, ARM, WAIT, REPORT)
  - channel index localparams CH_A=0, CH_B=1, CH_C=2
  - NUM_CH=3
  - function popcount3 for tie detection
- One sub-module sat_counter (parameter W; ports clk, rst, clr, inc, q), instanced for the three scores and round_cnt.
- Arm and timeout counters stay inline.
- Width of the timeout counter is $clog2(TIMEOUT_CYCLES+1).

Test Plan:
- Reset: rst=0 mid-WAIT with ARM_CYCLES=2 -> immediately det_rst_n=0, busy=0, winner=000, all scores 0. After release, det_rst_n=1 on the first edge.
- Single winner: start, detector b=1 after arm -> det_rst_n low exactly 2 cycles, done pulse of 1 cycle, winner=010, tie=0, score_b=1, round_cnt=1.
- Tie: start, a=c=1 same cycle -> winner=101, tie=1, score_a=1, score_c=1, score_b unchanged.
- Timeout: TIMEOUT_CYCLES=8, no inputs -> done exactly 8 WAIT cycles after ARM, winner=000, timeout=1, round_cnt increments, scores unchanged. Next round with a=1 -> timeout=0, winner=001.
- Abort/start-while-busy: abort during WAIT -> IDLE, no done, round_cnt unchanged. Start pulse during ARM -> no second round.
- Saturation/clear: CNT_W=2, four rounds won by a -> score_a=3. clr_scores coincident with a REPORT -> all counters 0 next cycle.

Source files
------------

// File: rtl/det_ctrl_pkg.sv
// Shared definitions for the detector round sequencer.
//   state_t    : sequencer FSM states
//   CH_A/B/C   : bit position of each channel in the detector's y vector
//   NUM_CH     : number of detector channels
//   popcount3  : number of set bits in a 3-bit vector (used for tie detection)
package det_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ARM    = 2'd1,
    WAIT   = 2'd2,
    REPORT = 2'd3
  } state_t;

  localparam int CH_A   = 0;
  localparam int CH_B   = 1;
  localparam int CH_C   = 2;
  localparam int NUM_CH = 3;

  function automatic logic [1:0] popcount3(input logic [2:0] v);
    return {1'b0, v[0]} + {1'b0, v[1]} + {1'b0, v[2]};
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear.
//   clk : system clock, rising edge
//   rst : asynchronous active-low reset, clears q
//   clr : synchronous clear, takes priority over inc
//   inc : increment request; ignored once q is all ones
//   q   : counter value
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] q
);

  logic [W-1:0] q_reg;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      q_reg <= '0;
    end else if (clr) begin
      q_reg <= '0;
    end else if (inc && (q_reg != {W{1'b1}})) begin
      q_reg <= q_reg + 1'b1;
    end
  end

  assign q = q_reg;

endmodule

// File: rtl/det_round_ctrl.sv
// Round sequencer for the three-input first-signal detector.
// Arms the detector by pulsing its active-low reset, waits for a non-zero
// y or a timeout, reports the result and keeps saturating win scores.
//   clk        : system clock, rising edge
//   rst        : asynchronous active-low reset
//   start      : one-cycle request to run a round (only honoured in IDLE)
//   abort      : cancel a round in ARM or WAIT
//   clr_scores : synchronous clear of all score and round counters
//   det_y      : detector output (bit0=a, bit1=b, bit2=c)
//   det_rst_n  : detector reset, low while arming
//   busy       : high in ARM, WAIT, REPORT
//   done       : one-cycle pulse in REPORT
//   timeout    : last completed round ended without a winner
//   winner     : det_y captured at round end (000 on timeout)
//   tie        : winner has more than one bit set
//   score_a/b/c: saturating per-channel win counts
//   round_cnt  : saturating count of completed rounds
module det_round_ctrl
  import det_ctrl_pkg::*;
#(
  parameter int ARM_CYCLES     = 2,
  parameter int TIMEOUT_CYCLES = 1000,
  parameter int CNT_W          = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic             clr_scores,
  input  logic [2:0]       det_y,
  output logic             det_rst_n,
  output logic             busy,
  output logic             done,
  output logic             timeout,
  output logic [2:0]       winner,
  output logic             tie,
  output logic [CNT_W-1:0] score_a,
  output logic [CNT_W-1:0] score_b,
  output logic [CNT_W-1:0] score_c,
  output logic [CNT_W-1:0] round_cnt
);

  localparam int AW   = (ARM_CYCLES > 1) ? $clog2(ARM_CYCLES + 1) : 1;
  localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);

  state_t            state_reg, state_next;
  logic [AW-1:0]     arm_cnt_reg;
  logic [TO_W-1:0]   to_cnt_reg;
  logic              det_rst_n_reg;
  logic [2:0]        winner_reg;
  logic              tie_reg;
  logic              timeout_reg;
  logic              enter_report;
  logic              in_report;
  logic [CNT_W-1:0]  score_q [NUM_CH];

  // Next-state logic. abort has priority over a detection seen in the
  // same WAIT cycle.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: begin
        if (start) state_next = ARM;
      end
      ARM: begin
        if (abort)                                  state_next = IDLE;
        else if (arm_cnt_reg == AW'(ARM_CYCLES - 1)) state_next = WAIT;
      end
      WAIT: begin
        if (abort)                                        state_next = IDLE;
        else if (det_y != 3'b000)                         state_next = REPORT;
        else if (to_cnt_reg == TO_W'(TIMEOUT_CYCLES - 1)) state_next = REPORT;
      end
      REPORT: begin
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign enter_report = (state_reg == WAIT) && (state_next == REPORT);
  assign in_report    = (state_reg == REPORT);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg     <= IDLE;
      arm_cnt_reg   <= '0;
      to_cnt_reg    <= '0;
      det_rst_n_reg <= 1'b0;
      winner_reg    <= 3'b000;
      tie_reg       <= 1'b0;
      timeout_reg   <= 1'b0;
    end else begin
      state_reg   <= state_next;
      arm_cnt_reg <= (state_reg == ARM)  ? arm_cnt_reg + 1'b1 : '0;
      to_cnt_reg  <= (state_reg == WAIT) ? to_cnt_reg + 1'b1  : '0;
      // Registered so the detector is held cleared during our own reset,
      // then released on the first edge afterwards.
      det_rst_n_reg <= (state_next != ARM);
      if (enter_report) begin
        // On timeout det_y is 000, so capturing it directly gives winner=000.
        winner_reg  <= det_y;
        tie_reg     <= (popcount3(det_y) > 2'd1);
        timeout_reg <= (det_y == 3'b000);
      end
    end
  end

  // Score counters: each channel scores when its bit is set in the
  // captured winner during REPORT; a tie credits every involved channel.
  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_score
    sat_counter #(.W(CNT_W)) u_score (
      .clk (clk),
      .rst (rst),
      .clr (clr_scores),
      .inc (in_report && winner_reg[gi]),
      .q   (score_q[gi])
    );
  end

  sat_counter #(.W(CNT_W)) u_round (
    .clk (clk),
    .rst (rst),
    .clr (clr_scores),
    .inc (in_report),
    .q   (round_cnt)
  );

  assign score_a   = score_q[CH_A];
  assign score_b   = score_q[CH_B];
  assign score_c   = score_q[CH_C];
  assign det_rst_n = det_rst_n_reg;
  assign busy      = (state_reg != IDLE);
  assign done      = in_report;
  assign winner    = winner_reg;
  assign tie       = tie_reg;
  assign timeout   = timeout_reg;

endmodule

// File: tb/tb_det_round_ctrl.sv
// Self-checking bench for det_round_ctrl: directed table of rounds,
// a mid-round reset sequence, then randomized rounds against a
// round-level reference model.
module tb_det_round_ctrl;

  localparam int ARM  = 2;
  localparam int TMO  = 8;
  localparam int CW   = 2;
  localparam int MAXC = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          start = 1'b0;
  logic          abort = 1'b0;
  logic          clr_scores = 1'b0;
  logic [2:0]    det_y = 3'b000;
  logic          det_rst_n, busy, done, timeout, tie;
  logic [2:0]    winner;
  logic [CW-1:0] score_a, score_b, score_c, round_cnt;

  int errors = 0;
  int checks = 0;

  // reference model state
  int         m_sa, m_sb, m_sc, m_rc;
  logic [2:0] m_win;
  logic       m_tie, m_to;

  det_round_ctrl #(
    .ARM_CYCLES     (ARM),
    .TIMEOUT_CYCLES (TMO),
    .CNT_W          (CW)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .abort      (abort),
    .clr_scores (clr_scores),
    .det_y      (det_y),
    .det_rst_n  (det_rst_n),
    .busy       (busy),
    .done       (done),
    .timeout    (timeout),
    .winner     (winner),
    .tie        (tie),
    .score_a    (score_a),
    .score_b    (score_b),
    .score_c    (score_c),
    .round_cnt  (round_cnt)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic int sat_inc(input int v);
    return (v < MAXC) ? v + 1 : v;
  endfunction

  task automatic model_reset;
    m_sa = 0; m_sb = 0; m_sc = 0; m_rc = 0;
    m_win = 3'b000; m_tie = 1'b0; m_to = 1'b0;
  endtask

  task automatic chk_counters;
    chk("score_a", score_a, m_sa);
    chk("score_b", score_b, m_sb);
    chk("score_c", score_c, m_sc);
    chk("round_cnt", round_cnt, m_rc);
  endtask

  // One round: winner pattern pat appears on det_y from WAIT cycle `delay`;
  // abort_at >= 0 asserts abort in that WAIT cycle; clr_rep raises
  // clr_scores during REPORT; sia pulses start during ARM.
  task automatic do_round(input int delay, input logic [2:0] pat, input int abort_at,
                          input bit clr_rep, input bit sia);
    int         exp_wait;
    bit         exp_abort;
    int         arm_low;
    int         w;
    logic [2:0] exp_win;
    exp_win   = (pat != 3'b000 && delay < TMO) ? pat : 3'b000;
    exp_wait  = (exp_win != 3'b000) ? delay + 1 : TMO;
    exp_abort = (abort_at >= 0) && (abort_at < exp_wait);
    if (exp_abort) exp_wait = abort_at + 1;

    start = 1'b1;
    tick;
    start = 1'b0;
    chk("busy_in_arm", busy, 1);

    arm_low = 0;
    while (det_rst_n == 1'b0 && arm_low < ARM + 4) begin
      if (sia && arm_low == 0) start = 1'b1;
      arm_low++;
      tick;
      start = 1'b0;
    end
    chk("arm_len", arm_low, ARM);

    w = 0;
    while (w < TMO + 4) begin
      det_y = (w >= delay) ? pat : 3'b000;
      abort = (w == abort_at);
      tick;
      abort = 1'b0;
      w++;
      if (done || !busy) break;
    end
    chk("wait_len", w, exp_wait);

    if (exp_abort) begin
      det_y = 3'b000;
      chk("abort_done", done, 0);
      chk("abort_busy", busy, 0);
      chk("abort_det_rst_n", det_rst_n, 1);
      chk("abort_winner_hold", winner, m_win);
      chk("abort_timeout_hold", timeout, m_to);
    end else begin
      m_win = exp_win;
      m_tie = ($countones(exp_win) > 1);
      m_to  = (exp_win == 3'b000);
      chk("done_pulse", done, 1);
      chk("winner", winner, m_win);
      chk("tie", tie, m_tie);
      chk("timeout", timeout, m_to);
      if (clr_rep) clr_scores = 1'b1;
      tick;
      clr_scores = 1'b0;
      det_y = 3'b000;
      chk("done_one_cycle", done, 0);
      chk("idle_after_report", busy, 0);
      if (clr_rep) begin
        m_sa = 0; m_sb = 0; m_sc = 0; m_rc = 0;
      end else begin
        if (m_win[0]) m_sa = sat_inc(m_sa);
        if (m_win[1]) m_sb = sat_inc(m_sb);
        if (m_win[2]) m_sc = sat_inc(m_sc);
        m_rc = sat_inc(m_rc);
      end
    end
    chk_counters();
    if (sia) begin
      tick;
      tick;
      chk("start_in_arm_dropped", busy, 0);
    end
    $display("round delay=%0d pat=%b abort_at=%0d clr=%0d -> winner=%b tie=%0d timeout=%0d rc=%0d",
             delay, pat, abort_at, clr_rep, winner, tie, timeout, round_cnt);
  endtask

  typedef struct {
    int         delay;
    logic [2:0] pat;
    int         abort_at;
    bit         clr_rep;
    bit         sia;
    logic [2:0] exp_win;
    logic       exp_tie;
    logic       exp_to;
  } vec_t;

  vec_t vecs [9];

  initial begin
    vecs[0] = '{0, 3'b010, -1, 1'b0, 1'b0, 3'b010, 1'b0, 1'b0};
    vecs[1] = '{2, 3'b101, -1, 1'b0, 1'b0, 3'b101, 1'b1, 1'b0};
    vecs[2] = '{0, 3'b000, -1, 1'b0, 1'b0, 3'b000, 1'b0, 1'b1};
    vecs[3] = '{3, 3'b001, -1, 1'b0, 1'b1, 3'b001, 1'b0, 1'b0};
    vecs[4] = '{5, 3'b100,  2, 1'b0, 1'b0, 3'b001, 1'b0, 1'b0};
    vecs[5] = '{7, 3'b001, -1, 1'b0, 1'b0, 3'b001, 1'b0, 1'b0};
    vecs[6] = '{1, 3'b001, -1, 1'b0, 1'b0, 3'b001, 1'b0, 1'b0};
    vecs[7] = '{0, 3'b110, -1, 1'b1, 1'b0, 3'b110, 1'b1, 1'b0};
    vecs[8] = '{9, 3'b010, -1, 1'b0, 1'b0, 3'b000, 1'b0, 1'b1};

    model_reset();
    #2;
    chk("rst_det_rst_n", det_rst_n, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_winner", winner, 0);
    chk_counters();
    rst = 1'b1;
    tick;
    chk("rel_det_rst_n", det_rst_n, 1);
    tick;

    for (int i = 0; i < 9; i++) begin
      do_round(vecs[i].delay, vecs[i].pat, vecs[i].abort_at, vecs[i].clr_rep, vecs[i].sia);
      chk("tbl_winner", winner, vecs[i].exp_win);
      chk("tbl_tie", tie, vecs[i].exp_tie);
      chk("tbl_timeout", timeout, vecs[i].exp_to);
    end
    chk("sat_round_cnt_after_clear", round_cnt, 1);

    // reset in the middle of WAIT
    start = 1'b1;
    tick;
    start = 1'b0;
    for (int i = 0; i < ARM + 1; i++) tick;
    chk("pre_rst_busy", busy, 1);
    rst = 1'b0;
    #1;
    chk("midrst_det_rst_n", det_rst_n, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_winner", winner, 0);
    chk("midrst_timeout", timeout, 0);
    model_reset();
    chk_counters();
    #3;
    rst = 1'b1;
    tick;
    chk("midrst_rel_det_rst_n", det_rst_n, 1);
    chk("midrst_rel_busy", busy, 0);
    $display("reset mid-WAIT -> det_rst_n=%0d busy=%0d", det_rst_n, busy);

    // randomized rounds
    for (int r = 0; r < 40; r++) begin
      int         d;
      logic [2:0] p;
      int         ab;
      d  = int'($urandom_range(0, 10));
      p  = 3'($urandom_range(0, 7));
      ab = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 8)) : -1;
      do_round(d, p, ab, ($urandom_range(0, 9) == 0), ($urandom_range(0, 4) == 0));
      if ($urandom_range(0, 7) == 0) begin
        clr_scores = 1'b1;
        tick;
        clr_scores = 1'b0;
        m_sa = 0; m_sb = 0; m_sc = 0; m_rc = 0;
        chk_counters();
        $display("idle clear -> round_cnt=%0d", round_cnt);
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // global watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
